prog_store: RTL and testbench
=============================

// Module: prog_store
// PURPOSE
//  Parametrised, writable program memory. Successor to the fixed 7-entry program ROM.
//  After reset it self-initialises every word to INIT_WORD, one word per clock.
//  A load port lets a loader or bench write program words at run time.
//  A request/valid fetch port returns {addr, word} lines to the sequencer with 1-cycle latency.
//  Out-of-range fetches are flagged, not aliased.
// PARAMETERS
//  ADDR_W    4      address width
//  DATA_W    42     program word width: {2b class, 4b op, 3x12b operands}
//  DEPTH     16     implemented words; legal range 1..2**ADDR_W
//  INIT_WORD 0      DATA_W-bit value every word takes during init
// PORTS
//  clk          in   1                  clock, rising edge
//  rst          in   1                  reset, synchronous, active-low
//  init_done    out  1                  1 = init finished, block operational
//  wr_en        in   1                  load-port write strobe
//  wr_addr      in   ADDR_W             load-port address
//  wr_data      in   DATA_W             load-port data
//  wr_ready     out  1                  load port accepts writes (== init_done)
//  fetch_req    in   1                  fetch request
//  fetch_addr   in   ADDR_W             fetch address
//  fetch_ready  out  1                  fetch accepted this cycle if req=1 (== init_done)
//  fetch_valid  out  1                  1-cycle pulse: fetch_line updated
//  fetch_line   out  ADDR_W+DATA_W      {fetch_addr, word}; held between fetches
//  fetch_fault  out  1                  fetch_addr >= DEPTH; valid alongside fetch_valid
// BEHAVIOUR
//  Reset (rst=0 at a clk edge):
//   - init_done=0, fetch_valid=0, fetch_fault=0, fetch_line=0, init_ptr=0.
//   - FSM goes to INIT.
//   - Applies in any state: a reset mid-INIT or mid-fetch restarts init, and all contents are re-initialised.
//  FSM states:
//   - INIT: each cycle writes mem[init_ptr]=INIT_WORD, then init_ptr++.
//     After writing DEPTH-1, go to RUN; init_done=1 from that edge on.
//     INIT therefore lasts exactly DEPTH cycles after rst releases.
//   - RUN: terminal state until the next reset.
//  INIT behaviour:
//   - wr_ready=fetch_ready=0.
//   - wr_en and fetch_req are ignored and dropped, not queued.
//  Load port (RUN only):
//   - wr_en=1 at an edge: mem[wr_addr] <= wr_data.
//   - wr_addr >= DEPTH: write silently discarded.
//  Fetch port (RUN only):
//   - A fetch is accepted when fetch_req & fetch_ready at an edge.
//   - Next cycle: fetch_valid=1, fetch_line={fetch_addr, mem[fetch_addr]}, fetch_fault=0.
//   - Back-to-back requests give one line per cycle, full throughput.
//   - No accepted fetch: fetch_valid=0 next cycle; fetch_line and fetch_fault hold their values.
//  Boundary conditions:
//   - fetch_addr >= DEPTH: fetch_valid=1, fetch_fault=1, fetch_line={fetch_addr, INIT_WORD}.
//   - Write and fetch to the same address in the same cycle: read-before-write, so the fetch
//     returns the old word. A fetch the following cycle returns the new word.
//   - DEPTH == 2**ADDR_W: fault is never raised.
//  Arithmetic:
//   - init_ptr is ADDR_W+1 bits wide, so no wrap at DEPTH=2**ADDR_W.
//   - Address compares are unsigned.
// CONFIGURATION
//  PROG_STORE_PARITY_EN defined:
//   - Each word stores an extra even-parity bit, computed on every write (load and init).
//   - Extra output par_err (out, 1): asserted with fetch_valid when the stored word+parity is odd.
//   - par_err clears to 0 on reset and on any fetch that checks clean.
//   - fetch_line is unchanged, and the word is returned even on error.
//  PROG_STORE_PARITY_EN undefined:
//   - No parity storage and no par_err port; behaviour otherwise identical.
// TESTING
//  1. Release rst at cycle 0 with DEPTH=16 -> init_done=0 for cycles 0..15, 1 at 16.
//     Then fetch addr 3 -> line {4'h3, INIT_WORD}.
//  2. Write addr 0..6 with {2'h0,4'h5,12'dN,24'h0}, N=1..7, then fetch 0..6 back-to-back
//     -> 7 consecutive valid pulses, lines {addr, op 5, N}, fault=0.
//  3. DEPTH=7: fetch addr 9 -> valid=1, fault=1, line={4'h9, INIT_WORD}.
//     Write to addr 12 -> later fetch 12 still faults, and no legal word changes.
//  4. Same-cycle write 42'hABC and fetch to addr 2 (old word X) -> returns X.
//     Next-cycle fetch of addr 2 -> 42'hABC.
//  5. Pull rst low for 1 cycle mid-stream after loading data -> valid=0, line=0,
//     init_done low for DEPTH cycles, then a fetch of any loaded address returns INIT_WORD.
//  6. With PROG_STORE_PARITY_EN: force-flip one stored bit at addr 5, fetch 5 -> par_err=1.
//     Fetch addr 4 -> par_err=0.

Source files
------------

// File: rtl/prog_store.sv
// prog_store: writable program memory that self-initialises to INIT_WORD after reset,
// with a run-time load port and a 1-cycle-latency fetch port returning {addr, word}.
// Optional feature macro: PROG_STORE_PARITY_EN adds a stored even-parity bit per word
// and a par_err output qualified by fetch_valid.
module prog_store #(
  parameter int unsigned       ADDR_W    = 4,
  parameter int unsigned       DATA_W    = 42,
  parameter int unsigned       DEPTH     = 16,
  parameter logic [DATA_W-1:0] INIT_WORD = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     init_done,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     wr_ready,
  input  logic                     fetch_req,
  input  logic [ADDR_W-1:0]        fetch_addr,
  output logic                     fetch_ready,
  output logic                     fetch_valid,
  output logic [ADDR_W+DATA_W-1:0] fetch_line,
`ifdef PROG_STORE_PARITY_EN
  output logic                     par_err,
`endif
  output logic                     fetch_fault
);

  localparam int unsigned PTR_W = ADDR_W + 1;
`ifdef PROG_STORE_PARITY_EN
  localparam int unsigned MEM_W = DATA_W + 1;
`else
  localparam int unsigned MEM_W = DATA_W;
`endif

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [PTR_W-1:0]   init_ptr;
  logic [MEM_W-1:0]   mem [DEPTH];
  logic [MEM_W-1:0]   rd_entry;
  logic               init_last;
  logic               wr_in_range;
  logic               fetch_fault_c;
  logic               init_we_c;
  logic               wr_accept_c;
  logic               fetch_accept_c;

  // Stored entry for a data word (parity bit on top when enabled).
  function automatic logic [MEM_W-1:0] mk_entry(input logic [DATA_W-1:0] d);
`ifdef PROG_STORE_PARITY_EN
    return {^d, d};
`else
    return d;
`endif
  endfunction

  // Unsigned range compares; the extra pointer bit keeps DEPTH == 2**ADDR_W exact.
  assign init_last     = (init_ptr == PTR_W'(DEPTH - 1));
  assign wr_in_range   = ({1'b0, wr_addr} < PTR_W'(DEPTH));
  assign fetch_fault_c = !({1'b0, fetch_addr} < PTR_W'(DEPTH));
  assign rd_entry      = mem[fetch_addr];

  // Both ports are open exactly when the block is operational.
  assign wr_ready    = init_done;
  assign fetch_ready = init_done;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= ST_INIT;
    else      state <= state_next;
  end

  // Next-state logic: INIT walks every word once, RUN is terminal until reset.
  always_comb begin
    state_next = state;
    case (state)
      ST_INIT: if (init_last) state_next = ST_RUN;
      ST_RUN:  state_next = ST_RUN;
      default: state_next = ST_INIT;
    endcase
  end

  // Output decode: init writes during INIT, port accepts only during RUN.
  always_comb begin
    init_we_c      = 1'b0;
    wr_accept_c    = 1'b0;
    fetch_accept_c = 1'b0;
    case (state)
      ST_INIT: init_we_c = 1'b1;
      ST_RUN: begin
        wr_accept_c    = wr_en & wr_in_range;
        fetch_accept_c = fetch_req;
      end
      default: ;
    endcase
  end

  // Init pointer and operational flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      init_ptr  <= '0;
      init_done <= 1'b0;
    end else begin
      if (init_we_c) init_ptr <= init_ptr + PTR_W'(1);
      init_done <= (state_next == ST_RUN);
    end
  end

  // Memory array: init fill or load-port write (out-of-range writes dropped).
  always_ff @(posedge clk) begin
    if (rst) begin
      if (init_we_c)        mem[init_ptr[ADDR_W-1:0]] <= mk_entry(INIT_WORD);
      else if (wr_accept_c) mem[wr_addr]               <= mk_entry(wr_data);
    end
  end

  // Fetch response: read-before-write, line and fault hold between fetches.
  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_valid <= 1'b0;
      fetch_fault <= 1'b0;
      fetch_line  <= '0;
`ifdef PROG_STORE_PARITY_EN
      par_err     <= 1'b0;
`endif
    end else begin
      fetch_valid <= fetch_accept_c;
      if (fetch_accept_c) begin
        fetch_fault <= fetch_fault_c;
        fetch_line  <= {fetch_addr, fetch_fault_c ? INIT_WORD : rd_entry[DATA_W-1:0]};
`ifdef PROG_STORE_PARITY_EN
        par_err     <= !fetch_fault_c && (^rd_entry);
`endif
      end
    end
  end

endmodule

// File: tb/tb_prog_store.sv
// tb_prog_store: drives two prog_store instances (DEPTH=16 and DEPTH=7) with shared
// stimulus; a reference model queues expected fetch lines, a negedge monitor checks them.
module tb_prog_store;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 42;
  localparam int unsigned LW = AW + DW;
  localparam logic [DW-1:0] INIT = '0;
  localparam int DEP0 = 16;
  localparam int DEP1 = 7;

  typedef struct packed {
    logic [LW-1:0] line;
    logic          fault;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          fetch_req;
  logic [AW-1:0] fetch_addr;

  logic          done0, wrdy0, frdy0, val0, flt0;
  logic [LW-1:0] line0;
  logic          done1, wrdy1, frdy1, val1, flt1;
  logic [LW-1:0] line1;

  int            checks = 0;
  int            failures = 0;
  bit            armed = 1'b0;
  bit            last_edge_reset = 1'b0;
  int            cnt [2];
  int            dep [2];
  logic [DW-1:0] mm [2][16];
  exp_t          q0 [$];
  exp_t          q1 [$];
  logic [LW-1:0] held_line [2];
  logic          held_fault [2];

  always #5 clk = ~clk;

  prog_store #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEP0), .INIT_WORD(INIT)) u_dut16 (
    .clk(clk), .rst(rst), .init_done(done0),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wrdy0),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(frdy0),
    .fetch_valid(val0), .fetch_line(line0), .fetch_fault(flt0)
  );

  prog_store #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEP1), .INIT_WORD(INIT)) u_dut7 (
    .clk(clk), .rst(rst), .init_done(done1),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wrdy1),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(frdy1),
    .fetch_valid(val1), .fetch_line(line1), .fetch_fault(flt1)
  );

  // Reference behaviour of one instance at a clock edge.
  task automatic model_edge(input int k, input logic r, input logic we, input logic [AW-1:0] wa,
                            input logic [DW-1:0] wd, input logic fr, input logic [AW-1:0] fa);
    exp_t e;
    if (!r) begin
      cnt[k] = 0;
      for (int i = 0; i < 16; i++) mm[k][i] = INIT;
    end else if (cnt[k] < dep[k]) begin
      cnt[k] = cnt[k] + 1;
    end else begin
      if (fr) begin
        e.fault = (int'(fa) >= dep[k]);
        e.line  = {fa, e.fault ? INIT : mm[k][fa]};
        if (k == 0) q0.push_back(e);
        else        q1.push_back(e);
      end
      if (we && int'(wa) < dep[k]) mm[k][wa] = wd;
    end
  endtask

  // One clock of stimulus; the model follows the edge it was applied at.
  task automatic step(input logic r, input logic we, input logic [AW-1:0] wa,
                      input logic [DW-1:0] wd, input logic fr, input logic [AW-1:0] fa);
    @(negedge clk);
    rst = r; wr_en = we; wr_addr = wa; wr_data = wd; fetch_req = fr; fetch_addr = fa;
    @(posedge clk);
    model_edge(0, r, we, wa, wd, fr, fa);
    model_edge(1, r, we, wa, wd, fr, fa);
    last_edge_reset = !r;
    armed = 1'b1;
  endtask

  task automatic idle();
    step(1'b1, 1'b0, '0, '0, 1'b0, '0);
  endtask

  function automatic logic [DW-1:0] rnd_word();
    return {10'($urandom), 32'($urandom)};
  endfunction

  task automatic rnd_step(input logic r);
    step(r, 1'($urandom), 4'($urandom), rnd_word(), 1'($urandom), 4'($urandom));
  endtask

  // Compare one instance's outputs against the scoreboard.
  task automatic chk(input int k, input logic done, input logic rw, input logic rf,
                     input logic v, input logic f, input logic [LW-1:0] l);
    exp_t e;
    logic have;
    logic exp_done;
    exp_done = (cnt[k] >= dep[k]);
    checks++;
    if (done !== exp_done || rw !== exp_done || rf !== exp_done) begin
      failures++;
      $display("FAIL ready[d%0d] got done=%b wr_ready=%b fetch_ready=%b want %b",
               dep[k], done, rw, rf, exp_done);
    end
    if (last_edge_reset) begin
      held_line[k]  = '0;
      held_fault[k] = 1'b0;
    end
    have = (k == 0) ? (q0.size() > 0) : (q1.size() > 0);
    if (have) begin
      if (k == 0) e = q0.pop_front();
      else        e = q1.pop_front();
      held_line[k]  = e.line;
      held_fault[k] = e.fault;
    end
    checks++;
    if (v !== have || l !== held_line[k] || f !== held_fault[k]) begin
      failures++;
      $display("FAIL fetch[d%0d] got valid=%b line=%h fault=%b want valid=%b line=%h fault=%b",
               dep[k], v, l, f, have, held_line[k], held_fault[k]);
    end
  endtask

  // Monitor: sample away from the active edge.
  always @(negedge clk) begin
    if (armed) begin
      chk(0, done0, wrdy0, frdy0, val0, flt0, line0);
      chk(1, done1, wrdy1, frdy1, val1, flt1, line1);
    end
  end

  initial begin
    dep[0] = DEP0;
    dep[1] = DEP1;
    cnt[0] = 0;
    cnt[1] = 0;
    held_line[0] = '0; held_line[1] = '0;
    held_fault[0] = 1'b0; held_fault[1] = 1'b0;
    rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; fetch_req = 1'b0; fetch_addr = '0;

    // Reset, then init with random traffic that must be dropped while not ready.
    step(1'b0, 1'b0, '0, '0, 1'b0, '0);
    step(1'b0, 1'b0, '0, '0, 1'b0, '0);
    for (int i = 0; i < 16; i++) rnd_step(1'b1);
    step(1'b1, 1'b0, '0, '0, 1'b1, 4'h3);
    idle();

    // Load 0..6 then fetch them back-to-back.
    for (int n = 1; n <= 7; n++)
      step(1'b1, 1'b1, 4'(n - 1), {2'h0, 4'h5, 12'(n), 24'h0}, 1'b0, '0);
    for (int a = 0; a < 7; a++) step(1'b1, 1'b0, '0, '0, 1'b1, 4'(a));
    idle();

    // Out-of-range fetch and write.
    step(1'b1, 1'b0, '0, '0, 1'b1, 4'h9);
    step(1'b1, 1'b1, 4'hC, 42'h3FF_FFFF_FFFF, 1'b0, '0);
    step(1'b1, 1'b0, '0, '0, 1'b1, 4'hC);
    step(1'b1, 1'b0, '0, '0, 1'b1, 4'hF);
    for (int a = 0; a < 7; a++) step(1'b1, 1'b0, '0, '0, 1'b1, 4'(a));
    idle();

    // Same-cycle write and fetch, then fetch again.
    step(1'b1, 1'b1, 4'h2, 42'hABC, 1'b1, 4'h2);
    step(1'b1, 1'b0, '0, '0, 1'b1, 4'h2);
    idle();

    // Random traffic.
    for (int i = 0; i < 300; i++) rnd_step(1'b1);

    // Mid-stream reset with a fetch in flight, then reload check.
    step(1'b1, 1'b1, 4'h1, rnd_word(), 1'b1, 4'h1);
    step(1'b0, 1'b1, 4'h2, rnd_word(), 1'b1, 4'h2);
    for (int i = 0; i < 16; i++) rnd_step(1'b1);
    for (int a = 0; a < 16; a++) step(1'b1, 1'b0, '0, '0, 1'b1, 4'(a));
    for (int i = 0; i < 100; i++) rnd_step(1'b1);

    // Reset held several cycles during traffic.
    rnd_step(1'b0);
    rnd_step(1'b0);
    rnd_step(1'b0);
    for (int i = 0; i < 60; i++) rnd_step(1'b1);
    idle();
    idle();

    @(negedge clk);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
